// File: rtl/seg_scan_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_pkg : shared types, constants and helpers for the scanner |
// | Revision     : 1.0                                                 |
// +--------------------------------------------------------------------+
package seg_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_t;

  localparam logic [6:0] SEG_OFF_HI = 7'h00;
  localparam logic [6:0] SEG_OFF_LO = 7'h7F;
  localparam int         MAX_DIGITS = 9;
  localparam int         SEL_W      = 4;

  function automatic int cnt_width(input int dwell, input int blank);
    int m;
    m = (dwell > blank) ? dwell : blank;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

  function automatic logic [MAX_DIGITS-1:0] digit_onehot(input logic [SEL_W-1:0] idx);
    logic [MAX_DIGITS-1:0] oh;
    oh = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (idx == SEL_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | scan_timer : loadable down-counter with terminal-count flag        |
// | Revision   : 1.0                                                   |
// +--------------------------------------------------------------------+
module scan_timer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_count;

  // Load wins over decrement; the counter parks at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_tc = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------+
// | seg_scan_driver : blanked, time-multiplexed 7-seg digit scanner    |
// | Revision        : 1.0                                              |
// +--------------------------------------------------------------------+
module seg_scan_driver
  import seg_scan_pkg::*;
#(
  parameter int DIGITS         = 9,
  parameter int DWELL          = 1000,
  parameter int BLANK          = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  input  logic [6:0]            seg_in,
  output logic [SEL_W-1:0]      sel,
  output logic                  mux_en,
  output logic [6:0]            seg_out,
  output logic [MAX_DIGITS-1:0] digit_en,
  output logic                  frame_done
);

  localparam int               CNT_W      = cnt_width(DWELL, BLANK);
  localparam logic [6:0]       C_SEG_OFF  = SEG_ACTIVE_LOW ? SEG_OFF_LO : SEG_OFF_HI;
  localparam logic [SEL_W-1:0] C_LAST_IDX = SEL_W'(DIGITS - 1);
  localparam logic [CNT_W-1:0] C_BLANK_LD = CNT_W'(BLANK - 1);
  localparam logic [CNT_W-1:0] C_DWELL_LD = CNT_W'(DWELL - 1);

  scan_state_t           r_state, w_state_nxt;
  logic [SEL_W-1:0]      r_idx, w_idx_nxt;
  logic [SEL_W-1:0]      r_sel, w_sel_nxt;
  logic                  r_mux_en, w_mux_en_nxt;
  logic [6:0]            r_seg, w_seg_nxt;
  logic [MAX_DIGITS-1:0] r_digit, w_digit_nxt;
  logic                  r_frame, w_frame_nxt;

  logic                  w_tmr_load;
  logic [CNT_W-1:0]      w_tmr_val;
  logic                  w_tmr_dec;
  logic                  w_tc;
  logic [6:0]            w_seg_lit;
  logic                  w_wrap;
  logic [SEL_W-1:0]      w_idx_adv;

  scan_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .i_dec      (w_tmr_dec),
    .o_tc       (w_tc)
  );

  generate
    if (SEG_ACTIVE_LOW) begin : g_seg_low
      assign w_seg_lit = ~seg_in;
    end else begin : g_seg_high
      assign w_seg_lit = seg_in;
    end
  endgenerate

  assign w_wrap    = (r_idx == C_LAST_IDX);
  assign w_idx_adv = w_wrap ? '0 : r_idx + 1'b1;

  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_sel_nxt    = r_sel;
    w_mux_en_nxt = r_mux_en;
    w_seg_nxt    = r_seg;
    w_digit_nxt  = r_digit;
    w_frame_nxt  = 1'b0;
    w_tmr_load   = 1'b0;
    w_tmr_val    = C_BLANK_LD;
    w_tmr_dec    = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_idx_nxt    = '0;
        w_sel_nxt    = '0;
        w_mux_en_nxt = 1'b0;
        w_seg_nxt    = C_SEG_OFF;
        w_digit_nxt  = '0;
        if (run) begin
          w_state_nxt  = ST_BLANK;
          w_mux_en_nxt = 1'b1;
          w_tmr_load   = 1'b1;
        end
      end

      ST_BLANK: begin
        if (!run) begin
          w_state_nxt  = ST_IDLE;
          w_idx_nxt    = '0;
          w_sel_nxt    = '0;
          w_mux_en_nxt = 1'b0;
        end else if (w_tc) begin
          // r_seg doubles as the pattern latch: seg_in is captured here only.
          w_state_nxt = ST_SHOW;
          w_seg_nxt   = w_seg_lit;
          w_digit_nxt = digit_onehot(r_idx);
          w_tmr_load  = 1'b1;
          w_tmr_val   = C_DWELL_LD;
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      ST_SHOW: begin
        if (w_tc) begin
          w_idx_nxt   = w_idx_adv;
          w_frame_nxt = w_wrap;
          w_seg_nxt   = C_SEG_OFF;
          w_digit_nxt = '0;
          if (run) begin
            w_state_nxt = ST_BLANK;
            w_sel_nxt   = w_idx_adv;
            w_tmr_load  = 1'b1;
          end else begin
            w_state_nxt  = ST_IDLE;
            w_idx_nxt    = '0;
            w_sel_nxt    = '0;
            w_mux_en_nxt = 1'b0;
          end
        end else begin
          w_tmr_dec = 1'b1;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_idx    <= '0;
      r_sel    <= '0;
      r_mux_en <= 1'b0;
      r_seg    <= C_SEG_OFF;
      r_digit  <= '0;
      r_frame  <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_sel    <= w_sel_nxt;
      r_mux_en <= w_mux_en_nxt;
      r_seg    <= w_seg_nxt;
      r_digit  <= w_digit_nxt;
      r_frame  <= w_frame_nxt;
    end
  end

  assign sel        = r_sel;
  assign mux_en     = r_mux_en;
  assign seg_out    = r_seg;
  assign digit_en   = r_digit;
  assign frame_done = r_frame;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for seg_scan_driver: a 9-digit active-low instance and a 1-digit
// active-high instance, each checked every cycle against a position model.
module tb_seg_scan_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_i [2];
  logic [6:0] seg_i [2];
  logic [3:0] sel_o [2];
  logic       mux_o [2];
  logic [6:0] seg_o [2];
  logic [8:0] dig_o [2];
  logic       fd_o  [2];

  int mN [2] = '{9, 1};
  int mB [2] = '{2, 2};
  int mD [2] = '{4, 3};
  bit mLow [2] = '{1'b1, 1'b0};

  bit         m_act [2];
  int         m_p   [2];
  logic [6:0] m_pat [2];
  bit         m_fd  [2];

  int         cyc = 0;
  int         ncyc = 0;
  int         n_vec = 0;
  int         n_err = 0;
  bit         tog = 1'b0;
  bit         tog_last = 1'b0;
  logic [6:0] tog_junk = 7'h00;
  bit         per_chk [2];
  int         last_fd [2] = '{-1, -1};

  always #5 clk = ~clk;

  // Digit-0 source behaves like the mux (sel + 0x10), optionally garbled
  // on every cycle except the last blanking cycle.
  assign seg_i[0] = (tog && !tog_last) ? tog_junk : ({3'b000, sel_o[0]} + 7'h10);
  assign seg_i[1] = 7'(ncyc * 3 + 1);

  seg_scan_driver #(
    .DIGITS(9), .DWELL(4), .BLANK(2), .SEG_ACTIVE_LOW(1'b1)
  ) u_dut0 (
    .clk(clk), .reset(reset), .run(run_i[0]), .seg_in(seg_i[0]),
    .sel(sel_o[0]), .mux_en(mux_o[0]), .seg_out(seg_o[0]),
    .digit_en(dig_o[0]), .frame_done(fd_o[0])
  );

  seg_scan_driver #(
    .DIGITS(1), .DWELL(3), .BLANK(2), .SEG_ACTIVE_LOW(1'b0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .run(run_i[1]), .seg_in(seg_i[1]),
    .sel(sel_o[1]), .mux_en(mux_o[1]), .seg_out(seg_o[1]),
    .digit_en(dig_o[1]), .frame_done(fd_o[1])
  );

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d: actual=%0h required=%0h (cycle %0d)", nm, k, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_act[k] = 1'b0;
      m_p[k]   = 0;
      m_pat[k] = 7'h00;
      m_fd[k]  = 1'b0;
    end
  endtask

  // Position p counts cycles since scan start; digit = p / (B+D), phase = p % (B+D).
  task automatic model_step();
    int per, w, d;
    cyc++;
    if (reset) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        per = mB[k] + mD[k];
        w = m_p[k] % per;
        d = m_p[k] / per;
        m_fd[k] = 1'b0;
        if (!m_act[k]) begin
          if (run_i[k]) begin
            m_act[k] = 1'b1;
            m_p[k]   = 0;
          end
        end else if (w < mB[k]) begin
          if (!run_i[k]) m_act[k] = 1'b0;
          else begin
            if (w == mB[k] - 1) m_pat[k] = seg_i[k];
            m_p[k]++;
          end
        end else if (w == per - 1) begin
          m_fd[k] = (d == mN[k] - 1);
          if (run_i[k]) m_p[k] = (m_p[k] + 1) % (per * mN[k]);
          else m_act[k] = 1'b0;
        end else begin
          m_p[k]++;
        end
      end
    end
  endtask

  task automatic cmp_cycle();
    logic [3:0] es;
    logic       em;
    logic [8:0] ed;
    logic [6:0] eg;
    int per, w, d;
    for (int k = 0; k < 2; k++) begin
      es = 4'd0;
      em = 1'b0;
      ed = 9'h000;
      eg = mLow[k] ? 7'h7F : 7'h00;
      if (m_act[k]) begin
        per = mB[k] + mD[k];
        w = m_p[k] % per;
        d = m_p[k] / per;
        es = 4'(d);
        em = 1'b1;
        if (w >= mB[k]) begin
          ed = 9'h001 << d;
          eg = mLow[k] ? ~m_pat[k] : m_pat[k];
        end
      end
      chk("sel", k, 32'(sel_o[k]), 32'(es));
      chk("mux_en", k, 32'(mux_o[k]), 32'(em));
      chk("digit_en", k, 32'(dig_o[k]), 32'(ed));
      chk("seg_out", k, 32'(seg_o[k]), 32'(eg));
      chk("frame_done", k, 32'(fd_o[k]), 32'(m_fd[k]));
      if (!per_chk[k]) begin
        last_fd[k] = -1;
      end else if (fd_o[k]) begin
        if (last_fd[k] >= 0) chk("frame_period", k, 32'(cyc - last_fd[k]), (k == 0) ? 32'd54 : 32'd5);
        last_fd[k] = cyc;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      cmp_cycle();
      @(negedge clk);
      ncyc++;
      tog_last = m_act[0] && ((m_p[0] % (mB[0] + mD[0])) == mB[0] - 1);
      tog_junk = 7'(ncyc) ^ 7'h55;
    end
  endtask

  task automatic wait_p0(input int tgt);
    int n;
    n = 0;
    while (!(m_act[0] && m_p[0] == tgt) && n < 300) begin
      tick(1);
      n++;
    end
    if (n >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_p0: position %0d not reached within 300 cycles", tgt);
    end
  endtask

  initial begin
    reset = 1'b1;
    run_i[0] = 1'b0;
    run_i[1] = 1'b0;
    per_chk[0] = 1'b0;
    per_chk[1] = 1'b0;
    model_reset();

    tick(2);
    chk("rst_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("rst_seg", 0, 32'(seg_o[0]), 32'h7F);
    chk("rst_seg", 1, 32'(seg_o[1]), 32'h00);
    chk("rst_dig", 0, 32'(dig_o[0]), 32'h0);
    chk("rst_mux", 0, 32'(mux_o[0]), 32'h0);
    reset = 1'b0;
    tick(1);

    // Normal scan on both instances
    run_i[0] = 1'b1;
    run_i[1] = 1'b1;
    per_chk[0] = 1'b1;
    per_chk[1] = 1'b1;
    tick(21);
    chk("lit_d3_sel", 0, 32'(sel_o[0]), 32'h3);
    chk("lit_d3_dig", 0, 32'(dig_o[0]), 32'h008);
    chk("lit_d3_seg", 0, 32'(seg_o[0]), 32'h6C);
    chk("d1_wrap_fd", 1, 32'(fd_o[1]), 32'h1);
    chk("d1_wrap_dig", 1, 32'(dig_o[1]), 32'h0);
    tick(34);
    chk("frame_fd", 0, 32'(fd_o[0]), 32'h1);
    chk("frame_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("frame_dig", 0, 32'(dig_o[0]), 32'h0);
    chk("d1_lit_dig", 1, 32'(dig_o[1]), 32'h001);
    tick(2);
    chk("lit_d0_dig", 0, 32'(dig_o[0]), 32'h001);
    chk("lit_d0_seg", 0, 32'(seg_o[0]), 32'h6F);
    tick(60);

    // seg_in garbled everywhere except the last blanking cycle
    tog = 1'b1;
    tick(60);
    wait_p0(27);
    chk("tog_d4_dig", 0, 32'(dig_o[0]), 32'h010);
    chk("tog_d4_seg", 0, 32'(seg_o[0]), 32'h6B);
    tog = 1'b0;

    // run dropped mid-SHOW on digit 3
    wait_p0(21);
    per_chk[0] = 1'b0;
    run_i[0] = 1'b0;
    tick(2);
    chk("drop_show_dig", 0, 32'(dig_o[0]), 32'h008);
    tick(1);
    chk("drop_idle_dig", 0, 32'(dig_o[0]), 32'h0);
    chk("drop_idle_mux", 0, 32'(mux_o[0]), 32'h0);
    chk("drop_idle_seg", 0, 32'(seg_o[0]), 32'h7F);
    chk("drop_idle_fd", 0, 32'(fd_o[0]), 32'h0);
    tick(3);

    // run dropped during BLANK of digit 5
    run_i[0] = 1'b1;
    wait_p0(30);
    run_i[0] = 1'b0;
    tick(1);
    chk("blk_drop_mux", 0, 32'(mux_o[0]), 32'h0);
    chk("blk_drop_dig", 0, 32'(dig_o[0]), 32'h0);
    run_i[0] = 1'b1;
    tick(1);
    chk("restart_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("restart_mux", 0, 32'(mux_o[0]), 32'h1);
    tick(2);
    chk("restart_dig", 0, 32'(dig_o[0]), 32'h001);

    // Asynchronous reset while digit 7 is lit
    wait_p0(45);
    per_chk[0] = 1'b0;
    per_chk[1] = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    cmp_cycle();
    chk("d7_lit_dig", 0, 32'(dig_o[0]), 32'h080);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    chk("arst_dig", 0, 32'(dig_o[0]), 32'h0);
    chk("arst_seg", 0, 32'(seg_o[0]), 32'h7F);
    chk("arst_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("arst_mux", 0, 32'(mux_o[0]), 32'h0);
    chk("arst_seg", 1, 32'(seg_o[1]), 32'h00);
    @(negedge clk);
    reset = 1'b0;
    tick(1);
    chk("post_rst_sel", 0, 32'(sel_o[0]), 32'h0);
    chk("post_rst_mux", 0, 32'(mux_o[0]), 32'h1);
    chk("post_rst_mux", 1, 32'(mux_o[1]), 32'h1);
    per_chk[0] = 1'b1;
    per_chk[1] = 1'b1;
    tick(120);

    run_i[0] = 1'b0;
    run_i[1] = 1'b0;
    tick(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
